// File: rtl/shift_rows_serial_if.sv
// Column-stream bundle between the column source, the ShiftRows stage and MixColumns.
interface shift_rows_serial_if;
    localparam int unsigned WORD = 32;

    logic            in_valid;
    logic            in_ready;
    logic [WORD-1:0] in_col;
    logic            out_valid;
    logic            out_ready;
    logic [WORD-1:0] out_col;
    logic [1:0]      out_idx;
    logic            out_last;

    // ShiftRows stage view
    modport slave (
        input  in_valid, in_col, out_ready,
        output in_ready, out_valid, out_col, out_idx, out_last
    );

    // Column producer / consumer view
    modport master (
        output in_valid, in_col, out_ready,
        input  in_ready, out_valid, out_col, out_idx, out_last
    );
endinterface

// File: rtl/shift_rows_serial.sv
// Column-serial AES ShiftRows with a ping-pong state buffer feeding MixColumns.
module shift_rows_serial (
    input  logic               clk,
    input  logic               rst,
    shift_rows_serial_if.slave bus
);
    localparam int unsigned BYTE = 8;
    localparam int unsigned WORD = 4 * BYTE;
    localparam int unsigned NCOL = 4;

    logic [WORD-1:0] mem [2][NCOL];
    logic            wr_bank;
    logic [1:0]      wr_idx;
    logic            rd_bank;
    logic [1:0]      rd_idx;
    logic [1:0]      full;

    logic            in_fire;
    logic            out_fire;
    logic            valid_c;
    logic [WORD-1:0] shifted;
    logic [1:0]      src;

    assign bus.in_ready  = !rst && !full[wr_bank];
    assign valid_c       = !rst && full[rd_bank];
    assign bus.out_valid = valid_c;
    assign bus.out_idx   = rst ? 2'd0 : rd_idx;
    assign bus.out_last  = valid_c && (rd_idx == 2'd3);
    assign bus.out_col   = valid_c ? shifted : '0;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = valid_c && bus.out_ready;

    // Row r of output column c is taken from buffered column (c + r) mod 4
    always_comb begin
        shifted = '0;
        src     = 2'd0;
        for (int r = 0; r < 4; r++) begin
            src = rd_idx + 2'(r);
            shifted[(3 - r) * BYTE +: BYTE] = mem[rd_bank][src][(3 - r) * BYTE +: BYTE];
        end
    end

    // State buffer write; contents are don't-care until the bank is marked full
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_bank][wr_idx] <= bus.in_col;
        end
    end

    // Write/read pointers and per-bank full flags; a completing write and read never share a bank
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= 2'd0;
            rd_bank <= 1'b0;
            rd_idx  <= 2'd0;
            full    <= 2'b00;
        end else begin
            if (in_fire) begin
                wr_idx <= wr_idx + 2'd1;
                if (wr_idx == 2'd3) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (out_fire) begin
                rd_idx <= rd_idx + 2'd1;
                if (rd_idx == 2'd3) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_rows_serial.sv
// Self-checking bench for shift_rows_serial: directed vector tables, corner sequences, random stream.
module tb_shift_rows_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_rows_serial_if bus ();

    shift_rows_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] col_in;
        logic [31:0] col_exp;
    } vec_t;

    vec_t tab [8];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, want %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: reference ShiftRows on accepted columns, compared at every output transfer
    logic [31:0] part [$];
    logic [31:0] expq [$];
    logic [31:0] mw;
    logic [31:0] hold_col;
    logic [1:0]  hold_idx;
    logic        hold_last;
    bit          stall = 1'b0;
    int          exp_idx = 0;
    int          out_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            part.delete();
            expq.delete();
            exp_idx = 0;
            stall   = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_col", bus.out_col, hold_col);
                chk("stall_idx", 32'(bus.out_idx), 32'(hold_idx));
                chk("stall_last", 32'(bus.out_last), 32'(hold_last));
            end
            if (!bus.out_valid) begin
                chk("idle_col_zero", bus.out_col, 32'h0);
            end
            if (bus.in_valid && bus.in_ready) begin
                part.push_back(bus.in_col);
                if (part.size() == 4) begin
                    for (int c = 0; c < 4; c++) begin
                        mw = 32'h0;
                        for (int r = 0; r < 4; r++) begin
                            mw[(3 - r) * 8 +: 8] = part[(c + r) % 4][(3 - r) * 8 +: 8];
                        end
                        expq.push_back(mw);
                    end
                    part.delete();
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got %08h, want no output at %0t", bus.out_col, $time);
                end else begin
                    chk("mon_col", bus.out_col, expq.pop_front());
                end
                chk("mon_idx", 32'(bus.out_idx), 32'(exp_idx));
                chk("mon_last", 32'(bus.out_last), 32'(exp_idx == 3));
                exp_idx = (exp_idx + 1) % 4;
            end
            stall     = bus.out_valid && !bus.out_ready;
            hold_col  = bus.out_col;
            hold_idx  = bus.out_idx;
            hold_last = bus.out_last;
        end
    end

    // Feed one table state back-to-back, then check its four shifted columns explicitly
    task automatic run_state(input int s);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_col   = tab[4 * s + c].col_in;
            @(negedge clk);
            chk("dir_in_ready", 32'(bus.in_ready), 32'(1));
            chk("dir_no_early_valid", 32'(bus.out_valid), 32'(0));
            tick();
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("dir_valid", 32'(bus.out_valid), 32'(1));
            chk("dir_col", bus.out_col, tab[4 * s + c].col_exp);
            chk("dir_idx", 32'(bus.out_idx), 32'(c));
            chk("dir_last", 32'(bus.out_last), 32'(c == 3));
            tick();
        end
    endtask

    initial begin
        int sent;
        int cyc;
        int k;
        int base_cnt;

        tab[0] = '{32'h00010203, 32'h00050a0f};
        tab[1] = '{32'h04050607, 32'h04090e03};
        tab[2] = '{32'h08090a0b, 32'h080d0207};
        tab[3] = '{32'h0c0d0e0f, 32'h0c01060b};
        tab[4] = '{32'hd42711ae, 32'hd4bf5d30};
        tab[5] = '{32'he0bf98f1, 32'he0b452ae};
        tab[6] = '{32'hb8b45de5, 32'hb84111f1};
        tab[7] = '{32'h1e415230, 32'h1e2798e5};

        bus.in_valid  = 1'b0;
        bus.in_col    = 32'h0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_col", bus.out_col, 32'h0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'(0));
        chk("rst_out_last", 32'(bus.out_last), 32'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
        tick();

        // Counting pattern and FIPS-197 round-1 vectors
        run_state(0);
        run_state(1);

        // Three back-to-back states: no input stall, one output per cycle after a 1-cycle gap
        bus.out_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            bus.in_valid = (c < 12);
            bus.in_col   = $urandom;
            @(negedge clk);
            if (c < 12) chk("stream_in_ready", 32'(bus.in_ready), 32'(1));
            chk("stream_out_valid", 32'(bus.out_valid), 32'(c >= 4 && c < 16));
            tick();
        end

        // Backpressure: both banks fill, output frozen, then drain in order
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_col   = (k < 8) ? tab[k].col_in : 32'hdeadbeef;
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'(c < 8));
            if (c >= 4) chk("bp_frozen_col", bus.out_col, tab[0].col_exp);
            if (bus.in_valid && bus.in_ready) k++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("drain_col", bus.out_col, tab[j].col_exp);
            chk("drain_idx", 32'(bus.out_idx), 32'(j % 4));
            chk("drain_in_ready", 32'(bus.in_ready), 32'(j >= 4));
            tick();
        end

        // Reset after a partial state
        for (int c = 0; c < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.in_col   = tab[4 + c].col_in;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst1_in_ready", 32'(bus.in_ready), 32'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst1_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst1_in_ready_after", 32'(bus.in_ready), 32'(1));
        tick();

        // Reset in the middle of draining a full state
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_col   = tab[4 + c].col_in;
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_pre_valid", 32'(bus.out_valid), 32'(1));
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_first_col", bus.out_col, tab[4].col_exp);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst2_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst2_out_col", bus.out_col, 32'h0);
        chk("rst2_out_idx", 32'(bus.out_idx), 32'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid_after", 32'(bus.out_valid), 32'(0));
        chk("rst2_in_ready_after", 32'(bus.in_ready), 32'(1));
        tick();
        run_state(0);

        // Random handshake toggling over 1000 states against the scoreboard
        base_cnt = out_cnt;
        sent = 0;
        cyc  = 0;
        while (sent < 4000 && cyc < 40000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_col    = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            cyc++;
        end
        chk("rand_sent", 32'(sent), 32'(4000));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while ((expq.size() != 0 || bus.out_valid) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("rand_drained", 32'(expq.size()), 32'(0));
        chk("rand_out_count", 32'(out_cnt - base_cnt), 32'(4000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
